// File: rtl/sn_stream_decoder.sv
// Stochastic-number stream decoder: counts ones over a selectable window and reports count plus bipolar value.
// Define SN_DECODE_BIPOLAR_EN to build the bipolar (2*ones - window) output; otherwise bipolar_out is tied to 0.
module sn_stream_decoder #(
  parameter int MAX_LOG2 = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sn_bit,
  input  logic                sn_valid,
  input  logic [1:0]          win_sel,
  input  logic                clear,
  output logic [MAX_LOG2:0]   count_out,
  output logic [MAX_LOG2+1:0] bipolar_out,
  output logic                out_valid,
  output logic                busy
);

  localparam int CW = MAX_LOG2 + 1;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t          state_q, state_d;
  logic [1:0]      win_q, win_d;
  logic [CW-1:0]   ones_q, ones_d;
  logic [CW-1:0]   samp_q, samp_d;
  logic [CW-1:0]   count_q, count_d;
  logic            valid_q, valid_d;

  logic            firstSample;
  logic [1:0]      winEff;
  logic [CW-1:0]   winLen;
  logic [CW-1:0]   onesNext;
  logic [CW-1:0]   sampNext;
  logic            winDone;

  // A fresh window (from IDLE or right after a completion) takes win_sel live; otherwise the latched value.
  always_comb begin
    firstSample = (state_q == IDLE) || (samp_q == '0);
    winEff      = firstSample ? win_sel : win_q;
    winLen      = CW'(8) << winEff;
    onesNext    = (firstSample ? '0 : ones_q) + CW'(sn_bit);
    sampNext    = (firstSample ? '0 : samp_q) + CW'(1);
    winDone     = !clear && sn_valid && (sampNext == winLen);
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    ones_d  = ones_q;
    samp_d  = samp_q;
    count_d = count_q;
    valid_d = 1'b0;
    if (clear) begin
      state_d = IDLE;
      ones_d  = '0;
      samp_d  = '0;
    end else if (sn_valid) begin
      state_d = ACCUM;
      win_d   = winEff;
      if (winDone) begin
        count_d = onesNext;
        valid_d = 1'b1;
        ones_d  = '0;
        samp_d  = '0;
      end else begin
        ones_d  = onesNext;
        samp_d  = sampNext;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= IDLE;
      win_q   <= '0;
      ones_q  <= '0;
      samp_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      ones_q  <= ones_d;
      samp_q  <= samp_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

`ifdef SN_DECODE_BIPOLAR_EN
  logic [CW:0]   bip_q, bip_d;
  logic [CW+1:0] bipDiff;

  // One extra bit of headroom so 2*ones (up to 128) cannot overflow before the subtraction.
  always_comb begin
    bipDiff = {1'b0, onesNext, 1'b0} - {2'b00, winLen};
    bip_d   = bip_q;
    if (winDone) begin
      bip_d = bipDiff[CW:0];
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      bip_q <= '0;
    end else begin
      bip_q <= bip_d;
    end
  end

  assign bipolar_out = bip_q;
`else
  assign bipolar_out = '0;
`endif

  assign count_out = count_q;
  assign out_valid = valid_q;
  assign busy      = (state_q == ACCUM);

endmodule

// File: tb/tb_sn_stream_decoder.sv
// Directed self-checking bench for sn_stream_decoder (default MAX_LOG2 = 6).
// Bipolar expectations follow SN_DECODE_BIPOLAR_EN: the computed value when defined, 0 otherwise.
module tb_sn_stream_decoder;

  logic       clk;
  logic       rst_n;
  logic       sn_bit;
  logic       sn_valid;
  logic [1:0] win_sel;
  logic       clear;
  logic [6:0] count_out;
  logic [7:0] bipolar_out;
  logic       out_valid;
  logic       busy;

  int passCnt  = 0;
  int failCnt  = 0;
  int checkCnt = 0;
  int early;
  int pulses;

  sn_stream_decoder #(.MAX_LOG2(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sn_bit     (sn_bit),
    .sn_valid   (sn_valid),
    .win_sel    (win_sel),
    .clear      (clear),
    .count_out  (count_out),
    .bipolar_out(bipolar_out),
    .out_valid  (out_valid),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int expBip(input int v);
`ifdef SN_DECODE_BIPOLAR_EN
    return v;
`else
    return 0;
`endif
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are sampled at that same point.
  task automatic applyStimulus(input logic v, input logic b);
    sn_valid = v;
    sn_bit   = b;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checkCnt++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int bipVal();
    return int'($signed(bipolar_out));
  endfunction

  initial begin
    rst_n    = 1'b1;
    sn_bit   = 1'b0;
    sn_valid = 1'b0;
    win_sel  = 2'd0;
    clear    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_count", int'(count_out), 0);
    checkOutput("rst_bip", bipVal(), 0);
    checkOutput("rst_valid", int'(out_valid), 0);
    checkOutput("rst_busy", int'(busy), 0);
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0);

    // Window of 8: 1,0,1,1,0,0,1,0 -> 4 ones, bipolar 0
    win_sel = 2'd0;
    applyStimulus(1'b1, 1'b1);
    checkOutput("w8_busy_first", int'(busy), 1);
    early = 0;
    applyStimulus(1'b1, 1'b0); early += int'(out_valid);
    applyStimulus(1'b1, 1'b1); early += int'(out_valid);
    applyStimulus(1'b1, 1'b1); early += int'(out_valid);
    applyStimulus(1'b1, 1'b0); early += int'(out_valid);
    applyStimulus(1'b1, 1'b0); early += int'(out_valid);
    applyStimulus(1'b1, 1'b1); early += int'(out_valid);
    checkOutput("w8_no_early_valid", early, 0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("w8_valid", int'(out_valid), 1);
    checkOutput("w8_count", int'(count_out), 4);
    checkOutput("w8_bip", bipVal(), expBip(0));
    applyStimulus(1'b0, 1'b0);
    checkOutput("w8_valid_pulse_end", int'(out_valid), 0);
    checkOutput("w8_busy_after", int'(busy), 1);
    checkOutput("w8_count_hold", int'(count_out), 4);

    // Window of 16, continuous: 16 zeros then 16 ones
    win_sel = 2'd1;
    early = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b0);
      if (i < 15) early += int'(out_valid);
    end
    checkOutput("w16z_no_early", early, 0);
    checkOutput("w16z_valid", int'(out_valid), 1);
    checkOutput("w16z_count", int'(count_out), 0);
    checkOutput("w16z_bip", bipVal(), expBip(-16));
    early = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b1);
      if (i < 15) early += int'(out_valid);
    end
    checkOutput("w16o_no_early", early, 0);
    checkOutput("w16o_valid", int'(out_valid), 1);
    checkOutput("w16o_count", int'(count_out), 16);
    checkOutput("w16o_bip", bipVal(), expBip(16));

    // Window of 64 ones with sn_valid toggling every other cycle
    win_sel = 2'd3;
    pulses = 0;
    for (int i = 0; i < 128; i++) begin
      applyStimulus((i % 2) == 0, 1'b1);
      pulses += int'(out_valid);
    end
    applyStimulus(1'b0, 1'b0); pulses += int'(out_valid);
    applyStimulus(1'b0, 1'b0); pulses += int'(out_valid);
    checkOutput("w64_pulses", pulses, 1);
    checkOutput("w64_count", int'(count_out), 64);
    checkOutput("w64_bip", bipVal(), expBip(64));
    checkOutput("w64_busy", int'(busy), 1);

    // win_sel changed mid-window is ignored; clear with a sample aborts the next window
    win_sel = 2'd0;
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    win_sel = 2'd2;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1);
    checkOutput("ws_valid_at8", int'(out_valid), 1);
    checkOutput("ws_count", int'(count_out), 8);
    checkOutput("ws_bip", bipVal(), expBip(8));
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0);
    clear = 1'b1;
    applyStimulus(1'b1, 1'b0);
    clear = 1'b0;
    checkOutput("clr_valid", int'(out_valid), 0);
    checkOutput("clr_busy", int'(busy), 0);
    checkOutput("clr_count_hold", int'(count_out), 8);
    checkOutput("clr_bip_hold", bipVal(), expBip(8));
    applyStimulus(1'b0, 1'b0);
    checkOutput("clr_busy_idle", int'(busy), 0);

    // Asynchronous reset mid-window discards the partial window
    win_sel = 2'd0;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1);
    #3;
    rst_n = 1'b1;
    #1;
    checkOutput("amid_count", int'(count_out), 0);
    checkOutput("amid_bip", bipVal(), 0);
    checkOutput("amid_valid", int'(out_valid), 0);
    checkOutput("amid_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0);
    early = 0;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, 1'b1);
      early += int'(out_valid);
    end
    checkOutput("post_rst_no_early", early, 0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("post_rst_valid", int'(out_valid), 1);
    checkOutput("post_rst_count", int'(count_out), 8);
    checkOutput("post_rst_bip", bipVal(), expBip(8));

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
